// File: rtl/rs_syndrome_stream.sv
// Symbol-serial Reed-Solomon syndrome engine: Horner accumulation of r(alpha^(FCR+j))
// per codeword, with a one-deep output register so the next codeword can stream in.
module rs_syndrome_stream #(
  parameter int SYMBOL_WIDTH = 3,
  parameter int N            = 7,
  parameter int NSYN         = 2,
  parameter int FCR          = 1,
  parameter int PRIM_POLY    = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SYMBOL_WIDTH-1:0]      in_symbol,
  input  logic                         in_last,
  output logic                         syn_valid,
  input  logic                         syn_ready,
  output logic [NSYN*SYMBOL_WIDTH-1:0] syndromes,
  output logic                         syn_zero,
  output logic                         syn_frame_err,
  output logic                         abort
);

  localparam int W  = SYMBOL_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0]  POLY_LO  = W'(PRIM_POLY);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  // Shift-and-add multiply; the x^m term of the polynomial is implied by the carry-out test.
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p;
    logic [W-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) p = p ^ x;
      x = x[W-1] ? ((x << 1) ^ POLY_LO) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [W-1:0] gf_alpha_pow(input int e);
    logic [W-1:0] r;
    r = W'(1);
    for (int k = 0; k < (e % ((1 << W) - 1)); k++) r = gf_mul(r, W'(2));
    return r;
  endfunction

  logic [CW-1:0]              count_q, count_d;
  logic [NSYN-1:0][W-1:0]     acc_q, acc_d, acc_upd;
  logic                       syn_valid_q, syn_valid_d;
  logic [NSYN*W-1:0]          syndromes_q, syndromes_d;
  logic                       syn_zero_q, syn_zero_d;
  logic                       syn_frame_err_q, syn_frame_err_d;
  logic                       abort_q, abort_d;
  logic                       accept;

  genvar gi;
  generate
    for (gi = 0; gi < NSYN; gi++) begin : g_root
      localparam logic [W-1:0] ROOT = gf_alpha_pow(FCR + gi);
      assign acc_upd[gi] = gf_mul(acc_q[gi], ROOT) ^ in_symbol;
    end
  endgenerate

  // Stall only the final symbol while a result is still held, so it never overwrites.
  assign in_ready = !(syn_valid_q && (count_q == LAST_IDX));
  assign accept   = in_valid && in_ready;

  always_comb begin
    count_d         = count_q;
    acc_d           = acc_q;
    syn_valid_d     = syn_valid_q;
    syndromes_d     = syndromes_q;
    syn_zero_d      = syn_zero_q;
    syn_frame_err_d = syn_frame_err_q;
    abort_d         = 1'b0;

    if (syn_valid_q && syn_ready) syn_valid_d = 1'b0;

    if (accept) begin
      if (count_q == LAST_IDX) begin
        syndromes_d     = acc_upd;
        syn_valid_d     = 1'b1;
        syn_zero_d      = (acc_upd == '0);
        syn_frame_err_d = !in_last;
        acc_d           = '0;
        count_d         = '0;
      end else if (in_last) begin
        acc_d   = '0;
        count_d = '0;
        abort_d = 1'b1;
      end else begin
        acc_d   = acc_upd;
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q         <= '0;
      acc_q           <= '0;
      syn_valid_q     <= 1'b0;
      syndromes_q     <= '0;
      syn_zero_q      <= 1'b0;
      syn_frame_err_q <= 1'b0;
      abort_q         <= 1'b0;
    end else begin
      count_q         <= count_d;
      acc_q           <= acc_d;
      syn_valid_q     <= syn_valid_d;
      syndromes_q     <= syndromes_d;
      syn_zero_q      <= syn_zero_d;
      syn_frame_err_q <= syn_frame_err_d;
      abort_q         <= abort_d;
    end
  end

  assign syn_valid     = syn_valid_q;
  assign syndromes     = syndromes_q;
  assign syn_zero      = syn_zero_q;
  assign syn_frame_err = syn_frame_err_q;
  assign abort         = abort_q;

endmodule

// File: tb/tb_rs_syndrome_stream.sv
// Directed bench for rs_syndrome_stream over GF(8), x^3+x+1, roots alpha^1=2 and alpha^2=4.
module tb_rs_syndrome_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_symbol;
  logic       in_last;
  logic       syn_valid;
  logic       syn_ready;
  logic [5:0] syndromes;
  logic       syn_zero;
  logic       syn_frame_err;
  logic       abort;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  rs_syndrome_stream #(
    .SYMBOL_WIDTH(3), .N(7), .NSYN(2), .FCR(1), .PRIM_POLY(11)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_symbol(in_symbol), .in_last(in_last),
    .syn_valid(syn_valid), .syn_ready(syn_ready), .syndromes(syndromes),
    .syn_zero(syn_zero), .syn_frame_err(syn_frame_err), .abort(abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive at a falling edge, wait (bounded) for in_ready, return at the falling edge after acceptance.
  task automatic send(input logic [2:0] s, input logic l);
    int waits;
    waits = 0;
    in_valid = 1'b1; in_symbol = s; in_last = l;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_cw(input logic [2:0] cw [7], input logic last_at_end);
    for (int i = 0; i < 7; i++) send(cw[i], (i == 6) && last_at_end);
  endtask

  // Packed view: {syn_valid, S1, S0, syn_zero, syn_frame_err}
  function automatic logic [8:0] outs();
    return {syn_valid, syndromes, syn_zero, syn_frame_err};
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_symbol = '0; in_last = 1'b0; syn_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({outs(), abort, in_ready} !== {9'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset got=%b required=%b", {outs(), abort, in_ready}, 11'b00000000001);
    end
    reset = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_zero_cw();
    logic [2:0] cw [7];
    cw = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    syn_ready = 1'b1;
    send_cw(cw, 1'b1);
    total++;
    if (outs() !== {1'b1, 3'd0, 3'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL zero_cw got=%b required=%b", outs(), {1'b1, 6'd0, 1'b1, 1'b0});
    end
    @(negedge clk);
    total++;
    if (syn_valid !== 1'b0) begin
      bad++; $display("FAIL zero_cw_pop syn_valid=%b required=0", syn_valid);
    end
    $display("zero codeword: syndromes=%h zero=%b", syndromes, syn_zero);
  endtask

  task automatic test_codeword();
    logic [2:0] cw [7];
    cw = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd6, 3'd3};
    syn_ready = 1'b1;
    send_cw(cw, 1'b1);
    total++;
    if (outs() !== {1'b1, 3'd0, 3'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL gen_codeword got=%b required=%b", outs(), {1'b1, 6'd0, 1'b1, 1'b0});
    end
    $display("generator codeword: syndromes=%h zero=%b", syndromes, syn_zero);
  endtask

  task automatic test_single_error();
    int         deg [5] = '{1, 2, 6, 0, 3};
    logic [2:0] val [5] = '{3'd1, 3'd1, 3'd1, 3'd5, 3'd3};
    logic [2:0] es0 [5] = '{3'd2, 3'd4, 3'd5, 3'd5, 3'd5};
    logic [2:0] es1 [5] = '{3'd4, 3'd6, 3'd7, 3'd5, 3'd4};
    logic [2:0] cw [7];
    syn_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 7; i++) cw[i] = (i == 6 - deg[k]) ? val[k] : 3'd0;
      send_cw(cw, 1'b1);
      total++;
      if (outs() !== {1'b1, es1[k], es0[k], 1'b0, 1'b0}) begin
        bad++; $display("FAIL single_err_%0d got=%b required=%b", k, outs(), {1'b1, es1[k], es0[k], 2'b00});
      end
      $display("error %0d at degree %0d: S0=%0d S1=%0d", val[k], deg[k], syndromes[2:0], syndromes[5:3]);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] a [7];
    logic [2:0] b [7];
    int start;
    a = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
    b = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
    syn_ready = 1'b1;
    start = cyc;
    send_cw(a, 1'b1);
    total++;
    if (outs() !== {1'b1, 3'd4, 3'd2, 2'b00}) begin
      bad++; $display("FAIL b2b_first got=%b required=%b", outs(), {1'b1, 3'd4, 3'd2, 2'b00});
    end
    send_cw(b, 1'b1);
    total++;
    if (outs() !== {1'b1, 3'd6, 3'd4, 2'b00}) begin
      bad++; $display("FAIL b2b_second got=%b required=%b", outs(), {1'b1, 3'd6, 3'd4, 2'b00});
    end
    total++;
    if (cyc - start !== 14) begin
      bad++; $display("FAIL b2b_cycles got=%0d required=14", cyc - start);
    end
    $display("back-to-back: two codewords in %0d cycles", cyc - start);
  endtask

  task automatic test_backpressure();
    logic [2:0] a [7];
    a = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
    @(negedge clk);
    syn_ready = 1'b0;
    send_cw(a, 1'b1);
    total++;
    if (outs() !== {1'b1, 3'd6, 3'd4, 2'b00}) begin
      bad++; $display("FAIL bp_held_a got=%b required=%b", outs(), {1'b1, 3'd6, 3'd4, 2'b00});
    end
    send(3'd1, 1'b0);
    for (int i = 0; i < 5; i++) send(3'd0, 1'b0);
    total++;
    if ({in_ready, outs()} !== {1'b0, 1'b1, 3'd6, 3'd4, 2'b00}) begin
      bad++; $display("FAIL bp_stall got=%b required=%b", {in_ready, outs()}, {2'b01, 3'd6, 3'd4, 2'b00});
    end
    in_valid = 1'b1; in_symbol = 3'd0; in_last = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, outs()} !== {1'b0, 1'b1, 3'd6, 3'd4, 2'b00}) begin
      bad++; $display("FAIL bp_stable got=%b required=%b", {in_ready, outs()}, {2'b01, 3'd6, 3'd4, 2'b00});
    end
    syn_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({syn_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL bp_pop got=%b required=01", {syn_valid, in_ready});
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    total++;
    if (outs() !== {1'b1, 3'd7, 3'd5, 2'b00}) begin
      bad++; $display("FAIL bp_b_result got=%b required=%b", outs(), {1'b1, 3'd7, 3'd5, 2'b00});
    end
    $display("backpressure: B syndromes=%h after pop of A", syndromes);
  endtask

  task automatic test_framing();
    logic [2:0] cw [7];
    cw = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
    syn_ready = 1'b1;
    @(negedge clk);
    send(3'd1, 1'b0); send(3'd2, 1'b0); send(3'd3, 1'b0);
    total++;
    if (abort !== 1'b0) begin
      bad++; $display("FAIL abort_idle abort=%b required=0", abort);
    end
    send(3'd4, 1'b1);
    total++;
    if ({abort, syn_valid} !== 2'b10) begin
      bad++; $display("FAIL abort_pulse got=%b required=10", {abort, syn_valid});
    end
    @(negedge clk);
    total++;
    if (abort !== 1'b0) begin
      bad++; $display("FAIL abort_width abort=%b required=0", abort);
    end
    send_cw(cw, 1'b1);
    total++;
    if (outs() !== {1'b1, 3'd4, 3'd2, 2'b00}) begin
      bad++; $display("FAIL after_abort got=%b required=%b", outs(), {1'b1, 3'd4, 3'd2, 2'b00});
    end
    send_cw(cw, 1'b0);
    total++;
    if (outs() !== {1'b1, 3'd4, 3'd2, 2'b01}) begin
      bad++; $display("FAIL frame_err got=%b required=%b", outs(), {1'b1, 3'd4, 3'd2, 2'b01});
    end
    $display("framing: abort seen, frame_err=%b", syn_frame_err);
  endtask

  task automatic test_reset_mid();
    logic [2:0] a [7];
    logic [2:0] b [7];
    a = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    b = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
    @(negedge clk);
    syn_ready = 1'b0;
    send_cw(a, 1'b1);
    send(3'd7, 1'b0); send(3'd7, 1'b0); send(3'd7, 1'b0);
    total++;
    if ({in_ready, syn_valid} !== 2'b11) begin
      bad++; $display("FAIL pre_reset got=%b required=11", {in_ready, syn_valid});
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({in_ready, outs()} !== {1'b1, 9'b0}) begin
      bad++; $display("FAIL mid_reset got=%b required=%b", {in_ready, outs()}, 10'b1000000000);
    end
    syn_ready = 1'b1;
    send_cw(b, 1'b1);
    total++;
    if (outs() !== {1'b1, 3'd4, 3'd2, 2'b00}) begin
      bad++; $display("FAIL post_reset got=%b required=%b", outs(), {1'b1, 3'd4, 3'd2, 2'b00});
    end
    $display("mid reset: recovered syndromes=%h", syndromes);
  endtask

  initial begin
    test_reset();
    test_zero_cw();
    test_codeword();
    test_single_error();
    test_back_to_back();
    test_backpressure();
    test_framing();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_syndrome_stream.md
Name: rs_syndrome_stream

Overview:
- Symbol-serial Reed-Solomon syndrome engine over GF(2^SYMBOL_WIDTH).
- Accepts one received symbol per cycle under a valid/ready handshake and computes NSYN syndromes S_j = r(alpha^(FCR+j)), j=0..NSYN-1, by Horner's rule.
- Emits the syndromes as one flat word with a separate output handshake, feeding the downstream error locator/corrector.
- Double-buffered: the next codeword accumulates while the previous result waits for the consumer.

Parameters:
- SYMBOL_WIDTH, 3, bits per symbol (m); field GF(2^m).
- N, 7, codeword length in symbols; 2 <= N <= 2^m-1.
- NSYN, 2, number of syndromes (2t); 1 <= NSYN < N.
- FCR, 1, first consecutive root exponent.
- PRIM_POLY, 11, primitive polynomial including the x^m term (0b1011 = x^3+x+1); alpha = 2.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  in_symbol/in_last valid
- in_ready  out  1  engine can accept a symbol this cycle
- in_symbol  in  SYMBOL_WIDTH  received symbol, highest-degree coefficient r_{N-1} first
- in_last  in  1  marks the final symbol (r_0) of a codeword
- syn_valid  out  1  syndromes held and valid
- syn_ready  in  1  consumer accepts syndromes
- syndromes  out  NSYN*SYMBOL_WIDTH  S_j occupies bits [j*SYMBOL_WIDTH +: SYMBOL_WIDTH]
- syn_zero  out  1  all syndromes zero (no detected error); qualified by syn_valid
- syn_frame_err  out  1  in_last was absent on symbol N-1; qualified by syn_valid
- abort  out  1  one-cycle pulse: early in_last, codeword discarded

Behaviour:
- Reset (synchronous, takes priority over everything):
  - count=0, all NSYN accumulators=0.
  - syn_valid=0, syndromes=0, syn_zero=0, syn_frame_err=0, abort=0.
  - Any in-flight codeword and any held result are dropped.
- Accept/handshake:
  - A symbol is accepted when in_valid && in_ready.
  - in_ready = !(syn_valid && count==N-1). It is a function of registered state only; it does not depend on syn_ready.
- Per accepted symbol with count < N-1 and in_last=0:
  - acc_j <= gfmul(acc_j, alpha^(FCR+j)) ^ in_symbol, for every j.
  - count <= count+1.
- Field arithmetic:
  - gfmul is polynomial multiply reduced by PRIM_POLY.
  - Constants alpha^(FCR+j) are elaborated at compile time; exponents are taken mod (2^m-1).
  - Addition is XOR.
  - All widths are exactly SYMBOL_WIDTH; no carries.
- Final symbol (accepted with count==N-1):
  - syndromes <= the updated acc values, i.e. the final Horner step is included.
  - syn_valid <= 1.
  - syn_zero <= (all updated acc == 0).
  - syn_frame_err <= !in_last.
  - acc <= 0, count <= 0. The next codeword may be accepted on the following cycle.
- Early last (accepted with in_last=1 and count < N-1):
  - Symbol discarded; acc <= 0, count <= 0.
  - abort=1 for exactly one cycle.
  - Held output is unaffected.
- Output handshake:
  - syn_valid && syn_ready clears syn_valid next cycle.
  - syndromes, syn_zero and syn_frame_err remain stable while syn_valid=1 && !syn_ready.
- Simultaneous pop and final symbol: if syn_valid && syn_ready and the final symbol of the next codeword is offered in the same cycle, in_ready=0 (count==N-1), so the symbol waits one cycle. No loss, no overwrite.
- Backpressure limit: while syn_valid is held, up to N-1 symbols of the next codeword are absorbed; in_ready then stalls at count==N-1.
- Throughput: with syn_ready held high, one codeword per N cycles, no bubbles.
- Latency: syn_valid rises the cycle after the final symbol is accepted.
- in_valid=0 cycles: state holds; accumulation resumes seamlessly.

Test Plan:
- Reset, then stream 7 zeros with in_last on the 7th and syn_ready=1 -> syn_valid=1 one cycle later, syndromes S0=0, S1=0, syn_zero=1, syn_frame_err=0.
- Valid codeword g(x)=x^2+6x+3, sent as 0,0,0,0,1,6,3 -> S0=0, S1=0, syn_zero=1.
- Single error value 1 at degree 1 (sequence 0,0,0,0,0,1,0) -> S0=2, S1=4, syn_zero=0. Same at degree 2 (0,0,0,0,1,0,0) -> S0=4, S1=6.
- Backpressure: hold syn_ready=0 after codeword A and stream codeword B:
  - in_ready drops after B's 6th symbol accepted; A's outputs stay stable.
  - Raise syn_ready -> A is popped, B's 7th symbol is accepted, B's syndromes appear.
- Framing: in_last on symbol 4 -> abort pulse, next full codeword gives correct syndromes. Seven symbols with no in_last -> syn_frame_err=1 with syndromes still computed.
- Reset asserted after symbol 3 and with a held result -> syn_valid=0, count=0. A subsequent single-error codeword yields S0=2, S1=4.
